code_lock: RTL and testbench
============================

# code_lock

Sequential keypad code checker sitting directly downstream of the per-button debouncers. It takes one debounced, multi-cycle-wide press signal per button and converts each rising edge into a key digit. Once CODE_LEN digits have been entered, it compares them against a parameter code and drives unlock, failure and lockout indications to the board LEDs and actuator logic. It counts failed attempts and enforces a timed lockout after MAX_TRIES consecutive failures.

## Interface
- NUM_KEYS, 4: number of buttons; button i enters digit value i.
- DIGIT_W, 2: bits per digit; NUM_KEYS ≤ 2^DIGIT_W.
- CODE_LEN, 4: digits per attempt, range 1–7.
- CODE, 8'b00_01_10_11: flat code, CODE_LEN*DIGIT_W bits; the first digit entered is in the MSBs.
- MAX_TRIES, 3: consecutive failures before lockout, range 1–7.
- LOCKOUT_CYCLES, 100_000_000: lockout duration in clk cycles.
- ENTRY_TIMEOUT, 500_000_000: idle cycles allowed mid-entry before the partial code is discarded.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst, input, 1: synchronous, active-high reset.
- key_pulse, input, NUM_KEYS: debounced press levels, one bit per button; each is high for many cycles per press.
- lock_req, input, 1: level; relocks while OPEN.
- unlocked, output, 1: level, high in OPEN.
- fail_pulse, output, 1: one-cycle strobe on each wrong code.
- lockout, output, 1: level, high in LOCKOUT.
- digit_count, output, 3: digits accepted in the current attempt.
- tries_left, output, 3: remaining attempts before lockout.

## Operation
- Edge detect:
  - key_q is a register of key_pulse; rise = key_pulse & ~key_q.
  - key_q resets to all ones, so a key held through reset never registers.
- Valid digit: exactly one rise bit set in a cycle where state is IDLE or ENTRY.
  - Two or more rise bits in the same cycle are ignored entirely: no digit, no attempt consumed.
- Valid digit handling:
  - The digit is shifted into the entry register (LSB side in, earlier digits move toward the MSBs).
  - digit_count increments.
  - The entry timer clears.
- States:
  - IDLE: locked, digit_count = 0. A valid digit moves to ENTRY, or straight to CHECK when CODE_LEN = 1.
  - ENTRY:
    - A valid digit that makes digit_count == CODE_LEN moves to CHECK.
    - The entry timer increments every cycle. When it reaches ENTRY_TIMEOUT-1 with no digit, go to IDLE, clear digit_count, leave tries_left unchanged.
  - CHECK: one cycle; compares the entry register to CODE.
    - Match: go to OPEN; tries_left = MAX_TRIES.
    - Mismatch: fail_pulse is asserted for the next cycle; tries_left decrements. If the new value is 0, go to LOCKOUT, otherwise go to IDLE.
    - digit_count clears in both cases.
  - OPEN:
    - unlocked = 1; keys are ignored.
    - lock_req sampled high moves to IDLE.
  - LOCKOUT:
    - Keys are ignored.
    - The counter runs from 0 to LOCKOUT_CYCLES-1, then the block goes to IDLE with tries_left = MAX_TRIES.
- key_q updates every cycle in every state. A key held when leaving LOCKOUT or OPEN therefore does not register.
- Reset values: state IDLE, unlocked 0, lockout 0, fail_pulse 0, digit_count 0, tries_left MAX_TRIES, all counters 0, entry register 0.
- rst during any state, including mid-entry, CHECK and LOCKOUT, takes effect on that edge: all partial entry is discarded and tries_left is restored.

## Timing
- Edge N is the first edge that samples key_pulse[i] high. The digit is accepted at edge N and digit_count shows the new value in the cycle after N.
- Last digit accepted at edge N:
  - State is CHECK during the cycle after edge N.
  - The CHECK outcome takes effect at edge N+1: unlocked or lockout rises, or fail_pulse is high for exactly one cycle.
  - tries_left updates at edge N+1.
- lock_req sampled high at edge M: unlocked is low from edge M onward.
- LOCKOUT entered at edge L: lockout is high for exactly LOCKOUT_CYCLES cycles and falls at edge L+LOCKOUT_CYCLES.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Bench parameters: LOCKOUT_CYCLES=20, ENTRY_TIMEOUT=50, default code.
- Correct code: press keys 0,1,2,3, each pulse 5 cycles wide with 3-cycle gaps → unlocked rises 2 edges after key 3 first goes high, tries_left = 3, fail_pulse never asserts. Then lock_req high for 1 cycle → unlocked = 0, state IDLE.
- Wrong code three times: enter 3,3,3,3 three times → fail_pulse strobes exactly 3 times, tries_left goes 2,1,0, lockout high for exactly 20 cycles, then tries_left = 3. Keys pressed during lockout leave digit_count at 0.
- Entry timeout: enter 0,1, then wait 60 cycles → digit_count returns to 0 and tries_left stays 3. A subsequent correct 0,1,2,3 unlocks.
- Simultaneous keys: key 0 and key 2 rise in the same cycle → digit_count unchanged. Then 0,1,2,3 unlocks.
- Reset mid-operation: assert rst after 2 digits, and separately during lockout → all outputs return to their reset values. A key held through rst deassertion produces no digit until it is released and pressed again.
- Held key across the lockout exit boundary: key 1 held high from cycle 10 of lockout until 5 cycles after lockout ends → no digit accepted; digit_count stays 0.

Source files
------------

// File: rtl/code_lock.sv
// code_lock: keypad code checker fed by per-button debounced press levels.
// Converts press edges to digits, checks the code, and enforces a timed lockout.
module code_lock #(
  parameter int unsigned                   NUM_KEYS       = 4,
  parameter int unsigned                   DIGIT_W        = 2,
  parameter int unsigned                   CODE_LEN       = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0]   CODE           = 8'b00_01_10_11,
  parameter int unsigned                   MAX_TRIES      = 3,
  parameter int unsigned                   LOCKOUT_CYCLES = 100_000_000,
  parameter int unsigned                   ENTRY_TIMEOUT  = 500_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_pulse,
  input  logic                lock_req,
  output logic                unlocked,
  output logic                fail_pulse,
  output logic                lockout,
  output logic [2:0]          digit_count,
  output logic [2:0]          tries_left
);

  localparam int unsigned EntryW = CODE_LEN * DIGIT_W;
  localparam int unsigned LockW  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int unsigned TimeW  = (ENTRY_TIMEOUT > 1) ? $clog2(ENTRY_TIMEOUT) : 1;

  localparam logic [LockW-1:0] LockLast = LockW'(LOCKOUT_CYCLES - 1);
  localparam logic [TimeW-1:0] TimeLast = TimeW'(ENTRY_TIMEOUT - 1);
  localparam logic [2:0]       TriesMax = 3'(MAX_TRIES);
  localparam logic [2:0]       CodeLen3 = 3'(CODE_LEN);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StEntry   = 3'd1;
  localparam logic [2:0] StCheck   = 3'd2;
  localparam logic [2:0] StOpen    = 3'd3;
  localparam logic [2:0] StLockout = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [NUM_KEYS-1:0] key_q;
  logic [EntryW-1:0]   entry_q, entry_d;
  logic [2:0]          count_q, count_d;
  logic [2:0]          tries_q, tries_d;
  logic [LockW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [TimeW-1:0]    timer_q, timer_d;
  logic                unlocked_q, lockout_q, fail_q, fail_d;

  logic [NUM_KEYS-1:0] rise;
  logic [DIGIT_W-1:0]  digit;
  logic                digit_valid;

  always_comb begin
    rise  = key_pulse & ~key_q;
    digit = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (rise[i]) digit = DIGIT_W'(i);
    end
    // Chords (several simultaneous rises) are dropped rather than guessed at.
    digit_valid = $onehot(rise) && ((state_q == StIdle) || (state_q == StEntry));
  end

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    count_d    = count_q;
    tries_d    = tries_q;
    lock_cnt_d = lock_cnt_q;
    timer_d    = timer_q;
    fail_d     = 1'b0;
    case (state_q)
      StIdle, StEntry: begin
        if (digit_valid) begin
          entry_d = (entry_q << DIGIT_W) | EntryW'(digit);
          count_d = count_q + 3'd1;
          timer_d = '0;
          state_d = (count_d == CodeLen3) ? StCheck : StEntry;
        end else if (state_q == StEntry) begin
          if (timer_q == TimeLast) begin
            state_d = StIdle;
            count_d = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TimeW'(1);
          end
        end
      end
      StCheck: begin
        count_d = '0;
        entry_d = '0;
        timer_d = '0;
        if (entry_q == CODE) begin
          state_d = StOpen;
          tries_d = TriesMax;
        end else begin
          fail_d     = 1'b1;
          tries_d    = tries_q - 3'd1;
          lock_cnt_d = '0;
          state_d    = (tries_d == 3'd0) ? StLockout : StIdle;
        end
      end
      StOpen: begin
        if (lock_req) state_d = StIdle;
      end
      StLockout: begin
        if (lock_cnt_q == LockLast) begin
          state_d    = StIdle;
          tries_d    = TriesMax;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LockW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      key_q      <= '1;
      entry_q    <= '0;
      count_q    <= '0;
      tries_q    <= TriesMax;
      lock_cnt_q <= '0;
      timer_q    <= '0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_pulse;
      entry_q    <= entry_d;
      count_q    <= count_d;
      tries_q    <= tries_d;
      lock_cnt_q <= lock_cnt_d;
      timer_q    <= timer_d;
      unlocked_q <= (state_d == StOpen);
      lockout_q  <= (state_d == StLockout);
      fail_q     <= fail_d;
    end
  end

  assign unlocked    = unlocked_q;
  assign lockout     = lockout_q;
  assign fail_pulse  = fail_q;
  assign digit_count = count_q;
  assign tries_left  = tries_q;

endmodule

// File: tb/tb_code_lock.sv
// Bench for code_lock: directed scenarios plus random key traffic, all checked each
// cycle against a queue-based behavioural model of the lock.
module tb_code_lock;

  localparam int unsigned NumKeys    = 4;
  localparam int unsigned DigitW     = 2;
  localparam int unsigned CodeLen    = 4;
  localparam int unsigned MaxTries   = 3;
  localparam int unsigned LockCycles = 20;
  localparam int unsigned Timeout    = 50;
  localparam logic [7:0]  Code       = 8'b00_01_10_11;
  localparam logic [7:0]  Wrong      = 8'b11_11_11_11;

  logic       clk;
  logic       rst;
  logic [3:0] key_pulse;
  logic       lock_req;
  logic       unlocked;
  logic       fail_pulse;
  logic       lockout;
  logic [2:0] digit_count;
  logic [2:0] tries_left;

  int n_tests = 0;
  int n_fail  = 0;
  int fail_cnt = 0;
  int lock_hi  = 0;

  code_lock #(
    .NUM_KEYS      (NumKeys),
    .DIGIT_W       (DigitW),
    .CODE_LEN      (CodeLen),
    .CODE          (Code),
    .MAX_TRIES     (MaxTries),
    .LOCKOUT_CYCLES(LockCycles),
    .ENTRY_TIMEOUT (Timeout)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .key_pulse  (key_pulse),
    .lock_req   (lock_req),
    .unlocked   (unlocked),
    .fail_pulse (fail_pulse),
    .lockout    (lockout),
    .digit_count(digit_count),
    .tries_left (tries_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: digits kept in a queue, lockout as a remaining-cycle budget.
  int  m_digits[$];
  int  m_tries, m_lock_left, m_idle;
  bit  m_open, m_fail, m_check;
  logic [3:0] m_prev;

  initial begin : model
    logic [3:0]  rise;
    logic [31:0] v;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_prev = '1;
        m_digits.delete();
        m_tries = MaxTries;
        m_open = 0; m_fail = 0; m_check = 0;
        m_lock_left = 0; m_idle = 0;
      end else begin
        rise   = key_pulse & ~m_prev;
        m_prev = key_pulse;
        m_fail = 0;
        if (m_check) begin
          v = 0;
          foreach (m_digits[i]) v = (v << DigitW) | 32'(m_digits[i]);
          if (v == 32'(Code)) begin
            m_open  = 1;
            m_tries = MaxTries;
          end else begin
            m_fail = 1;
            m_tries--;
            if (m_tries == 0) m_lock_left = LockCycles;
          end
          m_digits.delete();
          m_check = 0;
        end else if (m_open) begin
          if (lock_req) m_open = 0;
        end else if (m_lock_left > 0) begin
          m_lock_left--;
          if (m_lock_left == 0) m_tries = MaxTries;
        end else if ($countones(rise) == 1) begin
          for (int k = 0; k < NumKeys; k++) if (rise[k]) m_digits.push_back(k);
          m_idle = 0;
          if (m_digits.size() == CodeLen) m_check = 1;
        end else if (m_digits.size() > 0) begin
          m_idle++;
          if (m_idle == Timeout) begin
            m_digits.delete();
            m_idle = 0;
          end
        end
      end
      @(negedge clk);
      check("mdl_unlocked", unlocked, m_open);
      check("mdl_fail", fail_pulse, m_fail);
      check("mdl_lockout", lockout, (m_lock_left > 0));
      check("mdl_count", digit_count, m_digits.size());
      check("mdl_tries", tries_left, m_tries);
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (fail_pulse === 1'b1) fail_cnt++;
      if (lockout === 1'b1) lock_hi++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k, input int width, input int gap);
    @(negedge clk);
    key_pulse[k] = 1'b1;
    repeat (width) @(negedge clk);
    key_pulse[k] = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic enter_code(input logic [7:0] code, input int width, input int gap);
    for (int i = 0; i < CodeLen; i++) press(int'(code[(3-i)*2 +: 2]), width, gap);
  endtask

  task automatic pulse_lock_req();
    @(negedge clk);
    lock_req = 1'b1;
    @(negedge clk);
    lock_req = 1'b0;
  endtask

  task automatic pulse_rst(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_unlocked"}, unlocked, 0);
    check({tag, "_lockout"}, lockout, 0);
    check({tag, "_fail"}, fail_pulse, 0);
    check({tag, "_count"}, digit_count, 0);
    check({tag, "_tries"}, tries_left, MaxTries);
  endtask

  initial begin : stim
    int kind, w, g;
    logic [7:0] rc;
    rst = 1'b1;
    key_pulse = '0;
    lock_req = 1'b0;
    idle(3);
    check_reset_outputs("rst0");
    rst = 1'b0;
    idle(2);

    // Correct code with exact open timing.
    fail_cnt = 0;
    press(0, 5, 3); press(1, 5, 3); press(2, 5, 3);
    @(negedge clk);
    key_pulse[3] = 1'b1;
    @(negedge clk);
    check("open_early", unlocked, 0);
    @(negedge clk);
    check("open_edge", unlocked, 1);
    check("open_tries", tries_left, 3);
    idle(3);
    key_pulse[3] = 1'b0;
    idle(3);
    check("open_nofail", fail_cnt, 0);
    pulse_lock_req();
    @(negedge clk);
    check("relock", unlocked, 0);
    check("relock_count", digit_count, 0);

    // Three wrong attempts lead to a 20-cycle lockout.
    fail_cnt = 0;
    lock_hi  = 0;
    enter_code(Wrong, 5, 3);
    check("wrong1_tries", tries_left, 2);
    enter_code(Wrong, 5, 3);
    check("wrong2_tries", tries_left, 1);
    enter_code(Wrong, 5, 3);
    check("wrong3_tries", tries_left, 0);
    check("wrong3_lock", lockout, 1);
    press(0, 3, 2);
    check("lock_keys_ignored", digit_count, 0);
    idle(30);
    check("lock_over", lockout, 0);
    check("lock_tries", tries_left, 3);
    check("fail_strobes", fail_cnt, 3);
    check("lock_width", lock_hi, LockCycles);

    // Entry timeout discards a partial code.
    press(0, 5, 3); press(1, 5, 3);
    check("part_count", digit_count, 2);
    idle(60);
    check("timeout_count", digit_count, 0);
    check("timeout_tries", tries_left, 3);
    enter_code(Code, 5, 3);
    check("after_timeout_open", unlocked, 1);
    pulse_lock_req();

    // Chorded keys are ignored, from idle and mid-entry.
    @(negedge clk);
    key_pulse = 4'b0101;
    idle(4);
    key_pulse = '0;
    idle(3);
    check("chord_idle", digit_count, 0);
    press(0, 5, 3);
    @(negedge clk);
    key_pulse = 4'b0101;
    idle(4);
    key_pulse = '0;
    idle(3);
    check("chord_entry", digit_count, 1);
    press(1, 5, 3); press(2, 5, 3); press(3, 5, 3);
    check("chord_then_open", unlocked, 1);
    pulse_lock_req();

    // Reset mid-entry with a key held across reset release.
    press(0, 5, 3); press(1, 5, 3);
    @(negedge clk);
    rst = 1'b1;
    key_pulse[2] = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);
    check_reset_outputs("rst_entry");
    key_pulse[2] = 1'b0;
    idle(2);
    press(2, 4, 2);
    check("repress_count", digit_count, 1);
    pulse_rst(1);

    // Reset during lockout.
    enter_code(Wrong, 3, 2); enter_code(Wrong, 3, 2); enter_code(Wrong, 3, 2);
    idle(3);
    check("pre_rst_lock", lockout, 1);
    pulse_rst(1);
    @(negedge clk);
    check_reset_outputs("rst_lock");

    // Key held across the lockout exit.
    enter_code(Wrong, 5, 3); enter_code(Wrong, 5, 3); enter_code(Wrong, 5, 3);
    idle(3);
    key_pulse[1] = 1'b1;
    for (int i = 0; i < 40 && lockout === 1'b1; i++) @(negedge clk);
    check("held_lock_exit", lockout, 0);
    idle(5);
    key_pulse[1] = 1'b0;
    idle(3);
    check("held_no_digit", digit_count, 0);

    // Random traffic, checked by the model every cycle.
    pulse_rst(2);
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 11);
      w    = $urandom_range(1, 6);
      g    = $urandom_range(1, 4);
      case (kind)
        0, 1, 2:  enter_code(Code, w, g);
        3, 4, 5:  begin rc = 8'($urandom); enter_code(rc, w, g); end
        6, 7:     press($urandom_range(0, 3), w, g);
        8: begin
          @(negedge clk);
          key_pulse = 4'($urandom);
          repeat (w) @(negedge clk);
          key_pulse = '0;
          repeat (g) @(negedge clk);
        end
        9:        pulse_lock_req();
        10:       pulse_rst($urandom_range(1, 3));
        default:  idle(Timeout + 5);
      endcase
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
